can_rx_drain: RTL

- Bus initiator that autonomously empties the CAN controller's receive registers into a frame FIFO.
- It owns the controller's register port (cs/rs/bytesel/q). It polls the DLC/flags register, reads DATA0, DATA1 and ID for each available frame, then pushes the frame into an internal FIFO.
- The CPU pops whole frames from the FIFO, so received frames survive software latency without overwrite.

---
 rtl/can_rx_drain.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/can_rx_drain.sv
// ============================================================================
// can_rx_drain : polls a CAN controller's receive registers and moves each
//                frame into a frame FIFO that the CPU drains at its own pace.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module can_rx_drain #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  output logic                     can_cs,
  output logic [1:0]               can_rs,
  output logic [3:0]               can_bytesel,
  input  logic [31:0]              can_q,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [31:0]              rd_id,
  output logic [3:0]               rd_dlc,
  output logic                     rd_ovwr,
  output logic [31:0]              rd_data0,
  output logic [31:0]              rd_data1,
  output logic [$clog2(DEPTH):0]   fifo_cnt,
  output logic [7:0]               drop_cnt,
  input  logic                     drop_clr
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_POLL = 3'd1;
  localparam logic [2:0] S_RD0  = 3'd2;
  localparam logic [2:0] S_RD1  = 3'd3;
  localparam logic [2:0] S_RDID = 3'd4;

  localparam logic [1:0] c_RS_ID    = 2'b00;
  localparam logic [1:0] c_RS_DLCF  = 2'b01;
  localparam logic [1:0] c_RS_DATA0 = 2'b10;
  localparam logic [1:0] c_RS_DATA1 = 2'b11;

  logic [2:0]  r_state;
  logic [3:0]  r_dlc;
  logic        r_ovwr;
  logic [31:0] r_data0;
  logic [31:0] r_data1;

  logic [31:0] r_mem_id    [DEPTH];
  logic [3:0]  r_mem_dlc   [DEPTH];
  logic        r_mem_ovwr  [DEPTH];
  logic [31:0] r_mem_data0 [DEPTH];
  logic [31:0] r_mem_data1 [DEPTH];

  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic [7:0]  r_drop_cnt;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_accept;
  logic w_drop;

  assign w_empty  = (r_wptr == r_rptr);
  assign w_full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop    = !w_empty && rd_ready;
  assign w_push   = (r_state == S_RDID);
  // A full FIFO still takes the frame when the head leaves in the same cycle.
  assign w_accept = w_push && (!w_full || w_pop);
  assign w_drop   = w_push && !w_accept;

  always_comb begin
    can_cs = 1'b1;
    can_rs = c_RS_ID;
    case (r_state)
      S_POLL:  can_rs = c_RS_DLCF;
      S_RD0:   can_rs = c_RS_DATA0;
      S_RD1:   can_rs = c_RS_DATA1;
      S_RDID:  can_rs = c_RS_ID;
      default: can_cs = 1'b0;
    endcase
  end

  assign can_bytesel = 4'b0000;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_dlc   <= '0;
      r_ovwr  <= 1'b0;
      r_data0 <= '0;
      r_data1 <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (en) r_state <= S_POLL;
        S_POLL: begin
          r_dlc  <= can_q[3:0];
          r_ovwr <= can_q[7];
          if (can_q[6])  r_state <= S_RD0;
          else if (!en)  r_state <= S_IDLE;
        end
        S_RD0: begin
          r_data0 <= can_q;
          r_state <= S_RD1;
        end
        S_RD1: begin
          r_data1 <= can_q;
          r_state <= S_RDID;
        end
        S_RDID:  r_state <= S_POLL;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // The ID is written straight from the bus: it is only valid during RDID.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem_id   [r_wptr[AW-1:0]] <= can_q;
      r_mem_dlc  [r_wptr[AW-1:0]] <= r_dlc;
      r_mem_ovwr [r_wptr[AW-1:0]] <= r_ovwr;
      r_mem_data0[r_wptr[AW-1:0]] <= r_data0;
      r_mem_data1[r_wptr[AW-1:0]] <= r_data1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_accept) r_wptr <= r_wptr + 1'b1;
      if (w_pop)    r_rptr <= r_rptr + 1'b1;
      if (drop_clr)
        r_drop_cnt <= '0;
      else if (w_drop && (r_drop_cnt != 8'hFF))
        r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign rd_valid = !w_empty;
  assign rd_id    = w_empty ? '0   : r_mem_id   [r_rptr[AW-1:0]];
  assign rd_dlc   = w_empty ? '0   : r_mem_dlc  [r_rptr[AW-1:0]];
  assign rd_ovwr  = w_empty ? 1'b0 : r_mem_ovwr [r_rptr[AW-1:0]];
  assign rd_data0 = w_empty ? '0   : r_mem_data0[r_rptr[AW-1:0]];
  assign rd_data1 = w_empty ? '0   : r_mem_data1[r_rptr[AW-1:0]];
  assign fifo_cnt = r_wptr - r_rptr;
  assign drop_cnt = r_drop_cnt;

endmodule

`default_nettype wire
